// File: rtl/fetch_unit_queued_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_unit_queued_if                                             |
// | Redirect, instruction-memory and decode-handshake bundle.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface fetch_unit_queued_if #(
   parameter int XLEN    = 64,
   parameter int ILEN    = 32,
   parameter int IMEM_AW = 32
);
   logic                redirect_valid;
   logic [XLEN-1:0]     redirect_pc;
   logic                imem_req_valid;
   logic [IMEM_AW-1:0]  imem_addr;
   logic [ILEN-1:0]     imem_rdata;
   logic                out_valid;
   logic                out_ready;
   logic [ILEN-1:0]     out_instr;
   logic [XLEN-1:0]     out_pc;

   modport master (
      input  redirect_valid, redirect_pc, imem_rdata, out_ready,
      output imem_req_valid, imem_addr, out_valid, out_instr, out_pc
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_rdata, out_ready,
      input  imem_req_valid, imem_addr, out_valid, out_instr, out_pc
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit_queued.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_unit_queued                                                |
// | Registered-PC fetch stage with 1-cycle imem and a fetch FIFO.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_unit_queued #(
   parameter int              XLEN     = 64,
   parameter int              ILEN     = 32,
   parameter int              IMEM_AW  = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              FQ_DEPTH = 2
) (
   input  logic                clk,
   input  logic                reset,
   fetch_unit_queued_if.master bus
);
   localparam int c_cnt_w = $clog2(FQ_DEPTH + 1);
   localparam int c_ptr_w = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
   localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(FQ_DEPTH - 1);
   localparam logic [c_cnt_w:0]   c_depth    = (c_cnt_w + 1)'(FQ_DEPTH);

   logic [XLEN-1:0]    r_pc;
   logic [XLEN-1:0]    r_inflight_pc;
   logic               r_inflight;
   logic [c_cnt_w-1:0] r_count;
   logic [c_ptr_w-1:0] r_head;
   logic [c_ptr_w-1:0] r_tail;
   logic [ILEN-1:0]    r_instr_mem [FQ_DEPTH];
   logic [XLEN-1:0]    r_pc_mem    [FQ_DEPTH];

   logic               w_out_valid;
   logic               w_pop;
   logic               w_push;
   logic               w_issue;
   logic [c_cnt_w:0]   w_credit;

   function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
      return (p == c_last_ptr) ? '0 : p + 1'b1;
   endfunction

   // The head leaving this cycle frees its slot, which lets a depth-2
   // queue sustain one fetch per cycle.
   always_comb begin
      w_out_valid = 1'b0;
      w_pop       = 1'b0;
      w_push      = 1'b0;
      w_issue     = 1'b0;
      w_credit    = '0;
      w_out_valid = (r_count != '0) && !bus.redirect_valid && !reset;
      w_pop       = w_out_valid && bus.out_ready;
      w_push      = r_inflight && !bus.redirect_valid && !reset;
      w_credit    = {1'b0, r_count} + {{c_cnt_w{1'b0}}, r_inflight}
                  - {{c_cnt_w{1'b0}}, w_pop};
      w_issue     = !reset && !bus.redirect_valid && (w_credit < c_depth);
   end

   assign bus.imem_req_valid = w_issue;
   assign bus.imem_addr      = r_pc[IMEM_AW-1:0];
   assign bus.out_valid      = w_out_valid;
   assign bus.out_instr      = r_instr_mem[r_head];
   assign bus.out_pc         = r_pc_mem[r_head];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc          <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_count       <= '0;
         r_head        <= '0;
         r_tail        <= '0;
      end else if (bus.redirect_valid) begin
         r_pc       <= {bus.redirect_pc[XLEN-1:2], 2'b00};
         r_inflight <= 1'b0;
         r_count    <= '0;
         r_head     <= '0;
         r_tail     <= '0;
      end else begin
         if (w_issue) begin
            r_pc          <= r_pc + XLEN'(4);
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
         end else begin
            r_inflight <= 1'b0;
         end
         if (w_push) begin
            r_tail <= f_ptr_inc(r_tail);
         end
         if (w_pop) begin
            r_head <= f_ptr_inc(r_head);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Payload storage needs no reset; occupancy is tracked by r_count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_instr_mem[r_tail] <= bus.imem_rdata;
         r_pc_mem[r_tail]    <= r_inflight_pc;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit_queued.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fetch_unit_queued                                             |
// | Vector table plus queue scoreboard over four fetch-unit builds.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_fetch_unit_queued;
   localparam int NDUT = 4;

   function automatic int depth_of(input int k);
      case (k)
         2:       return 1;
         3:       return 3;
         default: return 2;
      endcase
   endfunction

   function automatic logic [63:0] rpc_of(input int k);
      return (k == 1) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'h0000_0000_0000_1000;
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [NDUT-1:0] rst_a;
   logic [NDUT-1:0] rv_a;
   logic [NDUT-1:0] rdy_a;
   logic [63:0]     rpc_a  [NDUT];
   logic [NDUT-1:0] req_a;
   logic [NDUT-1:0] ov_a;
   logic [31:0]     addr_a [NDUT];
   logic [31:0]     oin_a  [NDUT];
   logic [63:0]     opc_a  [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      fetch_unit_queued_if #(.XLEN(64), .ILEN(32), .IMEM_AW(32)) u_if ();
      fetch_unit_queued #(
         .XLEN(64), .ILEN(32), .IMEM_AW(32),
         .RESET_PC(rpc_of(g)), .FQ_DEPTH(depth_of(g))
      ) u_dut (
         .clk  (clk),
         .reset(rst_a[g]),
         .bus  (u_if)
      );
      assign u_if.redirect_valid = rv_a[g];
      assign u_if.redirect_pc    = rpc_a[g];
      assign u_if.out_ready      = rdy_a[g];
      assign req_a[g]  = u_if.imem_req_valid;
      assign addr_a[g] = u_if.imem_addr;
      assign ov_a[g]   = u_if.out_valid;
      assign oin_a[g]  = u_if.out_instr;
      assign opc_a[g]  = u_if.out_pc;
      // Memory returns the requested address as the instruction word.
      always @(posedge clk) u_if.imem_rdata <= u_if.imem_addr;
   end

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: every issued fetch is pushed with its issue cycle; the
   // front entry becomes presentable two cycles later and is popped on accept.
   logic [63:0] sb_pc  [NDUT][$];
   int          sb_cyc [NDUT][$];
   logic [63:0] m_pc   [NDUT];

   task automatic sb_step(input int k);
      logic ev, ei, pop;
      ev  = !rst_a[k] && !rv_a[k] && (sb_pc[k].size() != 0) && (cyc - sb_cyc[k][0] >= 2);
      pop = ev && rdy_a[k];
      ei  = !rst_a[k] && !rv_a[k] && ((sb_pc[k].size() - (pop ? 1 : 0)) < depth_of(k));
      chk($sformatf("sb%0d_req", k), 64'(req_a[k]), 64'(ei));
      chk($sformatf("sb%0d_valid", k), 64'(ov_a[k]), 64'(ev));
      if (ei && req_a[k])
         chk($sformatf("sb%0d_addr", k), 64'(addr_a[k]), 64'(m_pc[k][31:0]));
      if (ev && ov_a[k]) begin
         chk($sformatf("sb%0d_pc", k), opc_a[k], sb_pc[k][0]);
         chk($sformatf("sb%0d_instr", k), 64'(oin_a[k]), 64'(sb_pc[k][0][31:0]));
      end
      if (rst_a[k]) begin
         sb_pc[k].delete();
         sb_cyc[k].delete();
         m_pc[k] = rpc_of(k);
      end else if (rv_a[k]) begin
         sb_pc[k].delete();
         sb_cyc[k].delete();
         m_pc[k] = {rpc_a[k][63:2], 2'b00};
      end else begin
         if (pop) begin
            void'(sb_pc[k].pop_front());
            void'(sb_cyc[k].pop_front());
         end
         if (ei) begin
            sb_pc[k].push_back(m_pc[k]);
            sb_cyc[k].push_back(cyc);
            m_pc[k] = m_pc[k] + 64'd4;
         end
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < NDUT; k++) sb_step(k);
      cyc++;
   end

   typedef struct {
      bit          rst;
      bit          rv;
      logic [63:0] rpc;
      bit          rdy;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_val;
      logic [63:0] e_pc;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input bit rst, input bit rv, input logic [63:0] rpc, input bit rdy,
                               input bit e_req, input logic [31:0] e_addr,
                               input bit e_val, input logic [63:0] e_pc);
      vec_t v;
      v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
      v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc;
      tbl.push_back(v);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_a = '1;
      rv_a  = '0;
      rdy_a = '1;
      for (int k = 0; k < NDUT; k++) begin
         rpc_a[k] = '0;
         m_pc[k]  = rpc_of(k);
      end

      // Streaming with out_ready high
      add(1,0,0,1, 0,0,       0,0);
      add(1,0,0,1, 0,0,       0,0);
      add(0,0,0,1, 1,'h1000,  0,0);
      add(0,0,0,1, 1,'h1004,  0,0);
      add(0,0,0,1, 1,'h1008,  1,'h1000);
      add(0,0,0,1, 1,'h100c,  1,'h1004);
      add(0,0,0,1, 1,'h1010,  1,'h1008);
      // Backpressure: two fetches then stall until out_ready returns
      add(1,0,0,0, 0,0,       0,0);
      add(0,0,0,0, 1,'h1000,  0,0);
      add(0,0,0,0, 1,'h1004,  0,0);
      add(0,0,0,0, 0,0,       1,'h1000);
      add(0,0,0,0, 0,0,       1,'h1000);
      add(0,0,0,0, 0,0,       1,'h1000);
      add(0,0,0,0, 0,0,       1,'h1000);
      add(0,0,0,1, 1,'h1008,  1,'h1000);
      add(0,0,0,1, 1,'h100c,  1,'h1004);
      add(0,0,0,1, 1,'h1010,  1,'h1008);
      // Fill the queue, then redirect to an unaligned target
      add(0,0,0,0, 0,0,       1,'h100c);
      add(0,0,0,0, 0,0,       1,'h100c);
      add(0,1,'h2003,1, 0,0,  0,0);
      add(0,0,0,1, 1,'h2000,  0,0);
      add(0,0,0,1, 1,'h2004,  0,0);
      add(0,0,0,1, 1,'h2008,  1,'h2000);
      add(0,0,0,1, 1,'h200c,  1,'h2004);
      // Redirect in the response cycle of 0x1004, then reset mid-stream
      add(1,0,0,1, 0,0,       0,0);
      add(0,0,0,1, 1,'h1000,  0,0);
      add(0,0,0,1, 1,'h1004,  0,0);
      add(0,1,'h3000,1, 0,0,  0,0);
      add(0,0,0,1, 1,'h3000,  0,0);
      add(0,0,0,1, 1,'h3004,  0,0);
      add(0,0,0,1, 1,'h3008,  1,'h3000);
      add(1,0,0,1, 0,0,       0,0);
      add(0,0,0,1, 1,'h1000,  0,0);

      for (int i = 0; i < tbl.size(); i++) begin
         step();
         rst_a[0] = tbl[i].rst;
         rv_a[0]  = tbl[i].rv;
         rpc_a[0] = tbl[i].rpc;
         rdy_a[0] = tbl[i].rdy;
         @(negedge clk);
         chk($sformatf("vec%0d_req", i), 64'(req_a[0]), 64'(tbl[i].e_req));
         if (tbl[i].e_req)
            chk($sformatf("vec%0d_addr", i), 64'(addr_a[0]), 64'(tbl[i].e_addr));
         chk($sformatf("vec%0d_valid", i), 64'(ov_a[0]), 64'(tbl[i].e_val));
         if (tbl[i].e_val) begin
            chk($sformatf("vec%0d_pc", i), opc_a[0], tbl[i].e_pc);
            chk($sformatf("vec%0d_instr", i), 64'(oin_a[0]), 64'(tbl[i].e_pc[31:0]));
         end
      end

      // PC wrap from the top of the address space
      step();
      rst_a[1] = 1'b0;
      rdy_a[1] = 1'b1;
      @(negedge clk);
      chk("wrap_first_addr", 64'(addr_a[1]), 64'hFFFF_FFFC);
      begin
         int n;
         n = 0;
         while (!ov_a[1] && n < 10) begin
            @(negedge clk);
            n++;
         end
         chk("wrap_valid_seen", 64'(ov_a[1]), 64'd1);
         chk("wrap_pc0", opc_a[1], 64'hFFFF_FFFF_FFFF_FFFC);
         @(negedge clk);
         chk("wrap_valid1", 64'(ov_a[1]), 64'd1);
         chk("wrap_pc1", opc_a[1], 64'h0);
         chk("wrap_instr1", 64'(oin_a[1]), 64'h0);
      end

      // Random traffic on all builds; the scoreboard checks every cycle
      for (int c = 0; c < 600; c++) begin
         step();
         for (int k = 0; k < NDUT; k++) begin
            rst_a[k] = ($urandom_range(0, 59) == 0);
            rv_a[k]  = ($urandom_range(0, 11) == 0);
            rdy_a[k] = ($urandom_range(0, 2) != 0);
            rpc_a[k] = (k == 1) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15))
                                : {32'h0, $urandom};
         end
      end
      step();
      rst_a = '0;
      rv_a  = '0;
      rdy_a = '1;
      repeat (10) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
